// File: rtl/regfile_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
// Default widths describe a 32-entry, 32-bit register file.
package regfile_writeback_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] dest;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_ctrl_wb_write_queue.sv
// Circular pending-write FIFO: two pushes (push0 older than push1) and one pop per cycle.
// Entries are exported oldest-first so the bypass can scan them in age order.
module wb_write_queue
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push0_valid,
    input  logic [ADDR_W-1:0] push0_reg,
    input  logic [DATA_W-1:0] push0_data,
    input  logic              push1_valid,
    input  logic [ADDR_W-1:0] push1_reg,
    input  logic [DATA_W-1:0] push1_data,
    input  logic              pop,
    output logic [CW-1:0]     count,
    output logic [ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic [DEPTH-1:0]  entry_valid,
    output logic [ADDR_W-1:0] entry_reg [DEPTH],
    output logic [DATA_W-1:0] entry_data [DEPTH]
);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     tail_next;
    logic [CW-1:0]     push_n;

    assign push_n    = CW'(push0_valid) + CW'(push1_valid);
    assign tail_next = tail + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail  <= tail + PW'(push_n);
            count <= count + push_n - CW'(pop);
        end
    end

    // Payload storage needs no reset: an entry is only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push0_valid) begin
            mem_reg[tail]  <= push0_reg;
            mem_data[tail] <= push0_data;
        end
        if (push1_valid) begin
            mem_reg[push0_valid ? tail_next : tail]  <= push1_reg;
            mem_data[push0_valid ? tail_next : tail] <= push1_data;
        end
    end

    assign head_reg  = mem_reg[head];
    assign head_data = mem_data[head];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CW'(i) < count);
            entry_reg[i]   = mem_reg[head + PW'(i)];
            entry_data[i]  = mem_data[head + PW'(i)];
        end
    end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Writeback arbiter for the register-file write port: queues ALU/load results,
// commits one per cycle through a registered write port, and forwards pending data to readers.
module regfile_writeback_ctrl
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wb_valid,
    input  logic [ADDR_W-1:0] mem_wb_reg,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic              mem_wb_ready,
    input  logic              alu_wb_valid,
    input  logic [ADDR_W-1:0] alu_wb_reg,
    input  logic [DATA_W-1:0] alu_wb_data,
    output logic              alu_wb_ready,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [CW-1:0]     pending_count
);

    logic [CW-1:0]     free;
    logic              mem_push;
    logic              alu_push;
    logic              pop;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;
    logic [DEPTH-1:0]  entry_valid;
    logic [ADDR_W-1:0] entry_reg  [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];

    // Handshake: a source transfers on any rising edge where its valid and ready are both 1.
    // Ready depends only on queue occupancy (and mem_wb_valid for the ALU), never on the
    // source's own valid; load requests claim the last free slot ahead of the ALU.
    assign free         = CW'(DEPTH) - pending_count;
    assign mem_wb_ready = (free != '0);
    assign alu_wb_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_wb_valid);

    // Writes to the zero register complete the handshake but are discarded.
    assign mem_push = mem_wb_valid && mem_wb_ready && (mem_wb_reg != ADDR_W'(ZERO_REG));
    assign alu_push = alu_wb_valid && alu_wb_ready && (alu_wb_reg != ADDR_W'(ZERO_REG));
    assign pop      = (pending_count != '0);

    wb_write_queue #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push0_valid(mem_push),
        .push0_reg  (mem_wb_reg),
        .push0_data (mem_wb_data),
        .push1_valid(alu_push),
        .push1_reg  (alu_wb_reg),
        .push1_data (alu_wb_data),
        .pop        (pop),
        .count      (pending_count),
        .head_reg   (head_reg),
        .head_data  (head_data),
        .entry_valid(entry_valid),
        .entry_reg  (entry_reg),
        .entry_data (entry_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_reg    <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= pop;
            if (pop) begin
                rf_write_reg  <= head_reg;
                rf_write_data <= head_data;
            end
        end
    end

    assign rf_read_reg1 = rd_reg1;
    assign rf_read_reg2 = rd_reg2;

    logic [ADDR_W-1:0] port_reg [2];
    logic [DATA_W-1:0] port_raw [2];
    logic [DATA_W-1:0] port_out [2];

    assign port_reg[0] = rd_reg1;
    assign port_reg[1] = rd_reg2;
    assign port_raw[0] = rf_read_data1;
    assign port_raw[1] = rf_read_data2;

    // Later assignments override earlier ones, so the scan ends on the youngest match.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            port_out[p] = port_raw[p];
            if (rf_write_enable && (rf_write_reg == port_reg[p])) begin
                port_out[p] = rf_write_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_valid[i] && (entry_reg[i] == port_reg[p])) begin
                    port_out[p] = entry_data[i];
                end
            end
            if (port_reg[p] == ADDR_W'(ZERO_REG)) begin
                port_out[p] = '0;
            end
        end
    end

    assign rd_data1 = port_out[0];
    assign rd_data2 = port_out[1];

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the writeback rules.
module tb_regfile_writeback_ctrl;
    import regfile_writeback_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_wb_valid, alu_wb_valid;
    logic [AW-1:0] mem_wb_reg, alu_wb_reg;
    logic [DW-1:0] mem_wb_data, alu_wb_data;
    logic          mem_wb_ready, alu_wb_ready;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] rd_reg1, rd_reg2, rf_read_reg1, rf_read_reg2;
    logic [DW-1:0] rf_read_data1, rf_read_data2, rd_data1, rd_data2;
    logic [CW-1:0] pending_count;

    regfile_writeback_ctrl #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_wb_valid(mem_wb_valid), .mem_wb_reg(mem_wb_reg), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_reg(alu_wb_reg), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .pending_count(pending_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending writes in acceptance order, plus the last committed write on the port.
    wb_entry_t     m_q[$];
    bit            m_wen  = 1'b0;
    logic [AW-1:0] m_reg  = '0;
    logic [DW-1:0] m_data = '0;

    initial begin
        int        free;
        bit        mr, ar;
        wb_entry_t e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_wen  = 1'b0;
                m_reg  = '0;
                m_data = '0;
            end else begin
                free = DEPTH - m_q.size();
                mr   = (free >= 1);
                ar   = (free >= 2) || (free == 1 && !mem_wb_valid);
                if (m_q.size() > 0) begin
                    e      = m_q.pop_front();
                    m_wen  = 1'b1;
                    m_reg  = e.dest;
                    m_data = e.data;
                end else begin
                    m_wen = 1'b0;
                end
                if (mem_wb_valid && mr && mem_wb_reg != 0) begin
                    e.dest = mem_wb_reg;
                    e.data = mem_wb_data;
                    m_q.push_back(e);
                end
                if (alu_wb_valid && ar && alu_wb_reg != 0) begin
                    e.dest = alu_wb_reg;
                    e.data = alu_wb_data;
                    m_q.push_back(e);
                end
            end
        end
    end

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] r, input logic [DW-1:0] raw);
        if (r == 0) return '0;
        for (int i = m_q.size() - 1; i >= 0; i--) begin
            if (m_q[i].dest == r) return m_q[i].data;
        end
        if (m_wen && m_reg == r) return m_data;
        return raw;
    endfunction

    bit cmp_en = 1'b0;
    int c_free;

    always @(negedge clk) begin
        if (cmp_en) begin
            c_free = DEPTH - m_q.size();
            check("pending_count", 64'(pending_count), 64'(m_q.size()));
            check("mem_wb_ready", 64'(mem_wb_ready), 64'(c_free >= 1));
            check("alu_wb_ready", 64'(alu_wb_ready), 64'((c_free >= 2) || (c_free == 1 && !mem_wb_valid)));
            check("rf_write_enable", 64'(rf_write_enable), 64'(m_wen));
            check("rf_write_reg", 64'(rf_write_reg), 64'(m_reg));
            check("rf_write_data", 64'(rf_write_data), 64'(m_data));
            check("rf_read_reg1", 64'(rf_read_reg1), 64'(rd_reg1));
            check("rf_read_reg2", 64'(rf_read_reg2), 64'(rd_reg2));
            check("rd_data1", 64'(rd_data1), 64'(exp_read(rd_reg1, rf_read_data1)));
            check("rd_data2", 64'(rd_data2), 64'(exp_read(rd_reg2, rf_read_data2)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        mem_wb_valid = v;
        mem_wb_reg   = r;
        mem_wb_data  = d;
    endtask

    task automatic drive_alu(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        alu_wb_valid = v;
        alu_wb_reg   = r;
        alu_wb_data  = d;
    endtask

    task automatic set_reads(input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                             input logic [AW-1:0] r2, input logic [DW-1:0] d2);
        rd_reg1       = r1;
        rf_read_data1 = d1;
        rd_reg2       = r2;
        rf_read_data2 = d2;
    endtask

    // ---------------- stimulus ----------------
    int exp_cnt[6];

    initial begin
        rst = 1'b1;
        drive_mem(0, 0, 0);
        drive_alu(0, 0, 0);
        set_reads(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;
        #1;
        check("reset_count", 64'(pending_count), 0);
        check("reset_mem_ready", 64'(mem_wb_ready), 1);
        check("reset_alu_ready", 64'(alu_wb_ready), 1);
        check("reset_wen", 64'(rf_write_enable), 0);
        check("reset_wreg", 64'(rf_write_reg), 0);
        check("reset_wdata", 64'(rf_write_data), 0);

        // Single ALU write and its forwarding path.
        tick();
        drive_alu(1, 5, 32'hDEADBEEF);
        tick();
        drive_alu(0, 0, 0);
        set_reads(5, 0, 0, 0);
        #1;
        check("alu_q_count", 64'(pending_count), 1);
        check("alu_q_fwd", 64'(rd_data1), 64'h DEADBEEF);
        check("alu_q_wen", 64'(rf_write_enable), 0);
        tick();
        #1;
        check("alu_wen", 64'(rf_write_enable), 1);
        check("alu_wreg", 64'(rf_write_reg), 5);
        check("alu_wdata", 64'(rf_write_data), 64'h DEADBEEF);
        check("alu_out_fwd", 64'(rd_data1), 64'h DEADBEEF);
        tick();
        #1;
        check("alu_done_wen", 64'(rf_write_enable), 0);
        check("alu_done_raw", 64'(rd_data1), 0);

        // Same-cycle load and ALU write to r3: load is older.
        tick();
        drive_mem(1, 3, 1);
        drive_alu(1, 3, 2);
        tick();
        drive_mem(0, 0, 0);
        drive_alu(0, 0, 0);
        set_reads(0, 0, 3, 32'hAAAA);
        #1;
        check("waw_count", 64'(pending_count), 2);
        check("waw_fwd_q", 64'(rd_data2), 2);
        tick();
        #1;
        check("waw_first_wen", 64'(rf_write_enable), 1);
        check("waw_first_reg", 64'(rf_write_reg), 3);
        check("waw_first_data", 64'(rf_write_data), 1);
        check("waw_between_fwd", 64'(rd_data2), 2);
        tick();
        #1;
        check("waw_second_data", 64'(rf_write_data), 2);
        tick();
        #1;
        check("waw_idle_raw", 64'(rd_data2), 64'h AAAA);

        // Both sources valid every cycle: occupancy climbs 0,2,3 and the ALU is held off.
        exp_cnt = '{0, 2, 3, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            tick();
            drive_mem(1, AW'(i + 10), DW'(100 + i));
            drive_alu(1, AW'(i + 20), DW'(200 + i));
            #1;
            check("sat_count", 64'(pending_count), 64'(exp_cnt[i]));
            check("sat_mem_ready", 64'(mem_wb_ready), 1);
            check("sat_alu_ready", 64'(alu_wb_ready), (i >= 2) ? 64'd0 : 64'd1);
        end
        tick();
        drive_mem(0, 0, 0);
        drive_alu(0, 0, 0);
        repeat (6) tick();

        // Write to r0 is consumed and dropped.
        drive_alu(1, 0, 32'h1234);
        set_reads(0, 32'hFFFF_FFFF, 0, 0);
        #1;
        check("r0_ready", 64'(alu_wb_ready), 1);
        check("r0_read", 64'(rd_data1), 0);
        tick();
        drive_alu(0, 0, 0);
        #1;
        check("r0_count", 64'(pending_count), 0);
        check("r0_wen", 64'(rf_write_enable), 0);
        tick();
        #1;
        check("r0_wen_late", 64'(rf_write_enable), 0);

        // Three pending writes, then an asynchronous reset mid-cycle.
        drive_mem(1, 7, 32'h70);
        drive_alu(1, 8, 32'h80);
        tick();
        drive_mem(1, 9, 32'h90);
        drive_alu(1, 10, 32'hA0);
        tick();
        drive_mem(0, 0, 0);
        drive_alu(0, 0, 0);
        #1;
        check("pre_rst_count", 64'(pending_count), 3);
        #1;
        rst = 1'b1;
        #1;
        check("rst_count", 64'(pending_count), 0);
        check("rst_wen", 64'(rf_write_enable), 0);
        check("rst_wreg", 64'(rf_write_reg), 0);
        check("rst_wdata", 64'(rf_write_data), 0);
        tick();
        rst = 1'b0;
        set_reads(8, 32'h55, 10, 32'h66);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_wen", 64'(rf_write_enable), 0);
            check("post_rst_rd1", 64'(rd_data1), 64'h55);
            check("post_rst_rd2", 64'(rd_data2), 64'h66);
        end

        // Random traffic on a small register set to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            drive_mem($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom);
            drive_alu($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom);
            set_reads(AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom);
        end
        tick();
        rst = 1'b0;
        drive_mem(0, 0, 0);
        drive_alu(0, 0, 0);
        repeat (6) tick();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
